parity_sched: RTL and testbench
===============================

# parity_sched

Time-multiplexed parity sequencer and arbiter for the main-memory data path. Two requesters share a single 9-input parity tree: the write path asks for a generated parity bit, and the read path asks for a check. The block walks the word one byte per clock, folding in a running parity bit, and returns the result with a one-cycle acknowledge. Check failures are latched with the failing address for the error/status logic.

## Interface
Parameters:
- WIDTH, 32, data word width; must be a multiple of 8. NB = WIDTH/8 byte steps.
- ADDR_W, 22, width of the check address captured on error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- gen_req  in  1  generate request; held high until gen_ack.
- gen_data  in  WIDTH  word to generate parity for; sampled at grant only.
- gen_ack  out  1  one-cycle pulse: gen_par is valid.
- gen_par  out  1  odd-parity bit for gen_data.
- chk_req  in  1  check request; held high until chk_ack.
- chk_data  in  WIDTH  word read from memory; sampled at grant.
- chk_par  in  1  stored parity bit; sampled at grant.
- chk_addr  in  ADDR_W  address of the word; sampled at grant.
- chk_ack  out  1  one-cycle pulse: chk_err is valid.
- chk_err  out  1  high together with chk_ack if parity is bad.
- err_latched  out  1  sticky error flag.
- err_addr  out  ADDR_W  address of the first error since the last clear.
- err_cnt  out  8  error count, saturating at 255.
- err_clr  in  1  clears err_latched, err_addr and err_cnt.

## Operation
- Parity convention is odd: the data bits plus the parity bit contain an odd number of ones.
- The FSM has four states: IDLE, RUN, DONE_G and DONE_C.
  - IDLE: if any request is high, grant one. Latch the data word into a shift register, load acc, clear byte index idx, record owner, and go to RUN.
  - RUN: each clock, acc <= XOR of byte[idx] and acc (9-input tree), then idx++. After the edge that processes byte NB-1, go to DONE_G or DONE_C according to owner.
  - DONE_G: gen_ack=1, gen_par=~acc. Next state is IDLE.
  - DONE_C: chk_ack=1, chk_err=~acc. Next state is IDLE.
- acc load value:
  - Generate: acc=0.
  - Check: acc=chk_par. The result is good when the final acc=1.
- Arbitration is round-robin via the last_owner bit, updated at each grant.
  - On a tie, the requester that was not last served wins.
  - last_owner resets to CHK, so gen wins the first tie.
  - A lone request is granted immediately regardless of last_owner.
- A requester must deassert req on the edge ending its ack cycle. A req that is high in IDLE is treated as a new request.
- Error latch, evaluated in DONE_C with chk_err=1:
  - If err_latched=0: set it and capture the latched chk_addr.
  - If err_latched=1: err_addr is unchanged.
  - err_cnt increments, saturating at 255.
- err_clr in the same cycle as an error: clear-then-set. The result is err_latched=1, err_addr=new address, err_cnt=1.
- err_clr alone clears all three error outputs on the next edge.

## Timing
- Reset values:
  - State IDLE, idx 0, last_owner CHK.
  - gen_ack=0, gen_par=0, chk_ack=0, chk_err=0.
  - err_latched=0, err_addr=0, err_cnt=0.
- All outputs are registered; there is no combinational path from input to output.
- Latency: the ack is high in the cycle that starts NB+1 edges after the granting edge (5 for WIDTH=32).
- Minimum accept-to-accept spacing is NB+2 cycles: grant, NB RUN edges, DONE, then IDLE.
- gen_par and chk_err hold their last values after the ack. They are only meaningful while the ack is high.
- Inputs are don't-care after the grant edge; requesters may change data freely.
- Reset asserted mid-RUN or mid-DONE forces all outputs to reset values immediately (asynchronous). The aborted operation is never acknowledged, and requesters must re-request.
- Two acks are never high in the same cycle.

## Structure
- Shared package parity_pkg holds:
  - state enum: IDLE, RUN, DONE_G, DONE_C.
  - owner encoding: GEN=0, CHK=1.
  - ODD_PARITY=1 convention constant.
  - the NB computation.
- Sub-module parity9_tree is purely combinational: 9 inputs, even/odd outputs. It is instanced once, with inputs byte[idx] and acc. Only the odd output is used.
- The top level holds the FSM, shift register/mux, idx counter, arbiter bit, and error latch/counter. Target size is roughly 150–250 lines.

## Test plan
- Generate parity for two words, checking latency on the first:
  - gen_req with gen_data=0x00000000 → gen_ack exactly 5 cycles after grant, gen_par=1.
  - Repeat with 0x00000001 → gen_par=0.
- Check good then bad, with addr 0x12345:
  - chk_data=0xFFFFFFFF, chk_par=1 → chk_ack with chk_err=0.
  - Same data with chk_par=0 → chk_err=1, err_latched=1, err_addr=0x12345, err_cnt=1.
- Sticky error address:
  - A second bad check at addr 0x00777 → err_addr stays 0x12345, err_cnt=2.
  - Then 300 bad checks in total → err_cnt=255.
- Arbitration after reset:
  - gen_req and chk_req rise in the same cycle → gen served first, chk acked NB+2 cycles later.
  - Repeat the tie → order alternates (chk first).
- err_clr collision: err_clr pulsed in the DONE_C cycle of a bad check at addr 0x00AAA → err_latched=1, err_addr=0x00AAA, err_cnt=1.
- Reset mid-operation: reset asserted at the 2nd RUN cycle → acks never pulse, all outputs are 0 at once. After release, a new gen_req is acked normally with correct parity.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for the parity sequencer
package parity_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE_G, DONE_C} state_t;
  typedef enum logic {GEN = 1'b0, CHK = 1'b1} owner_t;
  localparam logic ODD_PARITY = 1'b1;
  function automatic int nb_of(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/parity9_tree.sv
// parity9_tree: combinational 9-input parity tree
//   in_i   : eight data bits plus the running parity bit
//   even_o : high when in_i holds an even number of ones
//   odd_o  : high when in_i holds an odd number of ones
module parity9_tree (
  input  logic [8:0] in_i,
  output logic       even_o,
  output logic       odd_o
);
  assign odd_o  = ^in_i;
  assign even_o = ~odd_o;
endmodule

// File: rtl/parity_sched.sv
// parity_sched: round-robin shared parity generator/checker, one byte per clock
//   gen_req/gen_data -> gen_ack/gen_par : odd-parity generation
//   chk_req/chk_data/chk_par/chk_addr -> chk_ack/chk_err : parity check
//   err_latched/err_addr/err_cnt : sticky error status, cleared by err_clr
module parity_sched
  import parity_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_req,
  input  logic [WIDTH-1:0]  gen_data,
  output logic              gen_ack,
  output logic              gen_par,
  input  logic              chk_req,
  input  logic [WIDTH-1:0]  chk_data,
  input  logic              chk_par,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_ack,
  output logic              chk_err,
  output logic              err_latched,
  output logic [ADDR_W-1:0] err_addr,
  output logic [7:0]        err_cnt,
  input  logic              err_clr
);
  localparam int NB = nb_of(WIDTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  state_t            state_q;
  owner_t            owner_q, last_q;
  logic [WIDTH-1:0]  sr_q;
  logic [IW-1:0]     idx_q;
  logic              acc_q, acc_d, even_unused;
  logic [ADDR_W-1:0] addr_q;
  logic              gen_ack_q, gen_par_q, chk_ack_q, chk_err_q, err_latched_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [7:0]        err_cnt_q;
  logic              take_chk;
  // check wins when it is alone or when generate was served last
  assign take_chk = chk_req & (~gen_req | (last_q == GEN));
  parity9_tree u_tree (
    .in_i   ({sr_q[7:0], acc_q}),
    .even_o (even_unused),
    .odd_o  (acc_d)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= GEN;
      last_q        <= CHK;
      sr_q          <= '0;
      idx_q         <= '0;
      acc_q         <= 1'b0;
      addr_q        <= '0;
      gen_ack_q     <= 1'b0;
      gen_par_q     <= 1'b0;
      chk_ack_q     <= 1'b0;
      chk_err_q     <= 1'b0;
      err_latched_q <= 1'b0;
      err_addr_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      gen_ack_q <= 1'b0;
      chk_ack_q <= 1'b0;
      if (err_clr) begin
        err_latched_q <= 1'b0;
        err_addr_q    <= '0;
        err_cnt_q     <= '0;
      end
      case (state_q)
        IDLE: if (gen_req | chk_req) begin
          sr_q    <= take_chk ? chk_data : gen_data;
          acc_q   <= take_chk & chk_par;
          idx_q   <= '0;
          owner_q <= take_chk ? CHK : GEN;
          last_q  <= take_chk ? CHK : GEN;
          if (take_chk) addr_q <= chk_addr;
          state_q <= RUN;
        end
        RUN: begin
          sr_q  <= sr_q >> 8;
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NB - 1)) state_q <= (owner_q == CHK) ? DONE_C : DONE_G;
        end
        DONE_G: begin
          gen_ack_q <= 1'b1;
          gen_par_q <= acc_q ^ ODD_PARITY;
          state_q   <= IDLE;
        end
        DONE_C: begin
          chk_ack_q <= 1'b1;
          chk_err_q <= acc_q ^ ODD_PARITY;
          // these assignments follow the clear above, so an error in the clear cycle re-arms the latch
          if (acc_q != ODD_PARITY) begin
            err_latched_q <= 1'b1;
            if (!err_latched_q || err_clr) err_addr_q <= addr_q;
            err_cnt_q <= err_clr ? 8'd1 : (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gen_ack     = gen_ack_q;
  assign gen_par     = gen_par_q;
  assign chk_ack     = chk_ack_q;
  assign chk_err     = chk_err_q;
  assign err_latched = err_latched_q;
  assign err_addr    = err_addr_q;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: randomized self-checking bench for parity_sched
module tb_parity_sched;
  localparam int WIDTH = 32;
  localparam int ADDR_W = 22;
  localparam int NB = WIDTH / 8;
  logic clk = 1'b0, reset = 1'b0;
  logic gen_req = 1'b0, gen_ack, gen_par;
  logic [WIDTH-1:0] gen_data = '0, chk_data = '0;
  logic chk_req = 1'b0, chk_par = 1'b0, chk_ack, chk_err;
  logic [ADDR_W-1:0] chk_addr = '0, err_addr;
  logic err_latched, err_clr = 1'b0;
  logic [7:0] err_cnt;
  int pass_cnt = 0, total_cnt = 0;
  logic m_latched;
  logic [ADDR_W-1:0] m_addr;
  int m_cnt;
  always #5 clk = ~clk;
  parity_sched #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .gen_req(gen_req), .gen_data(gen_data), .gen_ack(gen_ack), .gen_par(gen_par),
    .chk_req(chk_req), .chk_data(chk_data), .chk_par(chk_par), .chk_addr(chk_addr),
    .chk_ack(chk_ack), .chk_err(chk_err),
    .err_latched(err_latched), .err_addr(err_addr), .err_cnt(err_cnt), .err_clr(err_clr)
  );
  function automatic logic odd_bit(input logic [WIDTH-1:0] d);
    return ($countones(d) % 2) == 0;
  endfunction
  function automatic logic is_bad(input logic [WIDTH-1:0] d, input logic p);
    return (($countones(d) + int'(p)) % 2) == 0;
  endfunction
  task automatic do_gen(input logic [WIDTH-1:0] d, output logic par, output int k);
    gen_req = 1'b1; gen_data = d; k = 0; par = 1'b0;
    while (k < 20) begin
      @(negedge clk); k++;
      gen_data = $urandom;
      if (gen_ack) begin par = gen_par; break; end
    end
    gen_req = 1'b0;
  endtask
  task automatic do_chk(input logic [WIDTH-1:0] d, input logic p, input logic [ADDR_W-1:0] a, output logic err, output int k);
    chk_req = 1'b1; chk_data = d; chk_par = p; chk_addr = a; k = 0; err = 1'b0;
    while (k < 20) begin
      @(negedge clk); k++;
      chk_data = $urandom; chk_par = $urandom; chk_addr = ADDR_W'($urandom);
      if (chk_ack) begin err = chk_err; break; end
    end
    chk_req = 1'b0;
  endtask
  task automatic tie(input logic [WIDTH-1:0] gd, output int kg, output int kc, output logic gp, output logic ce, output logic overlap);
    gen_req = 1'b1; chk_req = 1'b1; gen_data = gd; chk_data = 32'h0000_0003; chk_par = 1'b1; chk_addr = 22'h1;
    kg = 0; kc = 0; gp = 1'b0; ce = 1'b1; overlap = 1'b0;
    for (int k = 1; k <= 30 && (kg == 0 || kc == 0); k++) begin
      @(negedge clk);
      if (gen_ack && chk_ack) overlap = 1'b1;
      if (gen_ack) begin kg = k; gp = gen_par; gen_req = 1'b0; end
      if (chk_ack) begin kc = k; ce = chk_err; chk_req = 1'b0; end
    end
    gen_req = 1'b0; chk_req = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1; gen_req = 1'b0; chk_req = 1'b0; err_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++; if (gen_ack !== 1'b0) $display("FAIL rst_gen_ack: got %0h exp 0", gen_ack); else pass_cnt++;
    total_cnt++; if (gen_par !== 1'b0) $display("FAIL rst_gen_par: got %0h exp 0", gen_par); else pass_cnt++;
    total_cnt++; if (chk_ack !== 1'b0) $display("FAIL rst_chk_ack: got %0h exp 0", chk_ack); else pass_cnt++;
    total_cnt++; if (chk_err !== 1'b0) $display("FAIL rst_chk_err: got %0h exp 0", chk_err); else pass_cnt++;
    total_cnt++; if (err_latched !== 1'b0) $display("FAIL rst_err_latched: got %0h exp 0", err_latched); else pass_cnt++;
    total_cnt++; if (err_addr !== '0) $display("FAIL rst_err_addr: got %0h exp 0", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: got %0d exp 0", err_cnt); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_gen;
    logic p; int k;
    do_gen(32'h0000_0000, p, k);
    total_cnt++; if (k - 1 !== NB + 1) $display("FAIL gen_latency: got %0d exp %0d", k - 1, NB + 1); else pass_cnt++;
    total_cnt++; if (p !== 1'b1) $display("FAIL gen_par_zero: got %0h exp 1", p); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (gen_ack !== 1'b0) $display("FAIL gen_ack_pulse: got %0h exp 0", gen_ack); else pass_cnt++;
    total_cnt++; if (gen_par !== 1'b1) $display("FAIL gen_par_hold: got %0h exp 1", gen_par); else pass_cnt++;
    do_gen(32'h0000_0001, p, k);
    total_cnt++; if (p !== 1'b0) $display("FAIL gen_par_one: got %0h exp 0", p); else pass_cnt++;
  endtask
  task automatic test_chk;
    logic e; int k;
    do_chk(32'hFFFF_FFFF, 1'b1, 22'h12345, e, k);
    total_cnt++; if (k - 1 !== NB + 1) $display("FAIL chk_latency: got %0d exp %0d", k - 1, NB + 1); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL chk_good: got %0h exp 0", e); else pass_cnt++;
    total_cnt++; if (err_latched !== 1'b0) $display("FAIL chk_good_latch: got %0h exp 0", err_latched); else pass_cnt++;
    do_chk(32'hFFFF_FFFF, 1'b0, 22'h12345, e, k);
    total_cnt++; if (e !== 1'b1) $display("FAIL chk_bad: got %0h exp 1", e); else pass_cnt++;
    total_cnt++; if (err_latched !== 1'b1) $display("FAIL chk_bad_latch: got %0h exp 1", err_latched); else pass_cnt++;
    total_cnt++; if (err_addr !== 22'h12345) $display("FAIL chk_bad_addr: got %0h exp 12345", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL chk_bad_cnt: got %0d exp 1", err_cnt); else pass_cnt++;
  endtask
  task automatic test_sticky;
    logic e; int k, nbad;
    logic [WIDTH-1:0] d;
    do_chk(32'h0000_0000, 1'b0, 22'h00777, e, k);
    total_cnt++; if (err_addr !== 22'h12345) $display("FAIL sticky_addr: got %0h exp 12345", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd2) $display("FAIL sticky_cnt2: got %0d exp 2", err_cnt); else pass_cnt++;
    nbad = 0;
    for (int i = 0; i < 298; i++) begin
      d = $urandom;
      do_chk(d, ~odd_bit(d), ADDR_W'($urandom), e, k);
      if (e === 1'b1) nbad++;
    end
    total_cnt++; if (nbad !== 298) $display("FAIL sticky_flags: got %0d exp 298", nbad); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd255) $display("FAIL sticky_sat: got %0d exp 255", err_cnt); else pass_cnt++;
    total_cnt++; if (err_addr !== 22'h12345) $display("FAIL sticky_addr_end: got %0h exp 12345", err_addr); else pass_cnt++;
  endtask
  task automatic test_arb;
    int kg, kc, k; logic gp, ce, ov, p;
    logic [WIDTH-1:0] d;
    test_reset();
    d = $urandom;
    tie(d, kg, kc, gp, ce, ov);
    total_cnt++; if (kg !== NB + 2) $display("FAIL arb1_gen_time: got %0d exp %0d", kg, NB + 2); else pass_cnt++;
    total_cnt++; if (kc !== 2 * (NB + 2)) $display("FAIL arb1_chk_time: got %0d exp %0d", kc, 2 * (NB + 2)); else pass_cnt++;
    total_cnt++; if (gp !== odd_bit(d)) $display("FAIL arb1_gen_par: got %0h exp %0h", gp, odd_bit(d)); else pass_cnt++;
    total_cnt++; if (ce !== 1'b0) $display("FAIL arb1_chk_err: got %0h exp 0", ce); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL arb1_overlap: got %0h exp 0", ov); else pass_cnt++;
    do_gen(32'h0F0F_0F0E, p, k);
    total_cnt++; if (p !== 1'b0) $display("FAIL arb_lone_gen: got %0h exp 0", p); else pass_cnt++;
    d = $urandom;
    tie(d, kg, kc, gp, ce, ov);
    total_cnt++; if (kc !== NB + 2) $display("FAIL arb2_chk_time: got %0d exp %0d", kc, NB + 2); else pass_cnt++;
    total_cnt++; if (kg !== 2 * (NB + 2)) $display("FAIL arb2_gen_time: got %0d exp %0d", kg, 2 * (NB + 2)); else pass_cnt++;
    total_cnt++; if (gp !== odd_bit(d)) $display("FAIL arb2_gen_par: got %0h exp %0h", gp, odd_bit(d)); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL arb2_overlap: got %0h exp 0", ov); else pass_cnt++;
  endtask
  task automatic test_clr;
    logic e; int k;
    do_chk(32'h0000_0001, 1'b1, 22'h00555, e, k);
    chk_req = 1'b1; chk_data = 32'h0000_0001; chk_par = 1'b1; chk_addr = 22'h00AAA;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      err_clr = (k == NB + 1);
      if (chk_ack) break;
    end
    chk_req = 1'b0; err_clr = 1'b0;
    total_cnt++; if (k !== NB + 2) $display("FAIL clr_ack_time: got %0d exp %0d", k, NB + 2); else pass_cnt++;
    total_cnt++; if (err_latched !== 1'b1) $display("FAIL clr_coll_latch: got %0h exp 1", err_latched); else pass_cnt++;
    total_cnt++; if (err_addr !== 22'h00AAA) $display("FAIL clr_coll_addr: got %0h exp aaa", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL clr_coll_cnt: got %0d exp 1", err_cnt); else pass_cnt++;
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total_cnt++; if (err_latched !== 1'b0) $display("FAIL clr_latch: got %0h exp 0", err_latched); else pass_cnt++;
    total_cnt++; if (err_addr !== '0) $display("FAIL clr_addr: got %0h exp 0", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL clr_cnt: got %0d exp 0", err_cnt); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    logic e, p, seen; int k;
    logic [WIDTH-1:0] d;
    do_chk(32'h0000_0000, 1'b0, 22'h00003, e, k);
    do_gen(32'h0000_0001, p, k);
    gen_req = 1'b1; gen_data = 32'h0000_0001;
    @(negedge clk); @(negedge clk);
    reset = 1'b1; gen_req = 1'b0;
    #1;
    total_cnt++; if ({gen_ack, gen_par, chk_ack, chk_err, err_latched} !== 5'b0) $display("FAIL mid_rst_flags: got %b exp 00000", {gen_ack, gen_par, chk_ack, chk_err, err_latched}); else pass_cnt++;
    total_cnt++; if (err_addr !== '0) $display("FAIL mid_rst_addr: got %0h exp 0", err_addr); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL mid_rst_cnt: got %0d exp 0", err_cnt); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); seen |= gen_ack | chk_ack; end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seen |= gen_ack | chk_ack; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL mid_rst_no_ack: got %0h exp 0", seen); else pass_cnt++;
    d = $urandom;
    do_gen(d, p, k);
    total_cnt++; if (k - 1 !== NB + 1) $display("FAIL mid_rst_latency: got %0d exp %0d", k - 1, NB + 1); else pass_cnt++;
    total_cnt++; if (p !== odd_bit(d)) $display("FAIL mid_rst_par: got %0h exp %0h", p, odd_bit(d)); else pass_cnt++;
  endtask
  task automatic test_random;
    logic e, p, bp; int k, op;
    logic [WIDTH-1:0] d;
    logic [ADDR_W-1:0] a;
    test_reset();
    m_latched = 1'b0; m_addr = '0; m_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      d = $urandom; a = ADDR_W'($urandom);
      if (op == 0) begin
        do_gen(d, p, k);
        total_cnt++; if (p !== odd_bit(d)) $display("FAIL rnd_gen_par[%0d]: got %0h exp %0h", i, p, odd_bit(d)); else pass_cnt++;
      end else if (op == 4) begin
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        m_latched = 1'b0; m_addr = '0; m_cnt = 0;
      end else begin
        bp = $urandom;
        do_chk(d, bp, a, e, k);
        total_cnt++; if (e !== is_bad(d, bp)) $display("FAIL rnd_chk_err[%0d]: got %0h exp %0h", i, e, is_bad(d, bp)); else pass_cnt++;
        if (is_bad(d, bp)) begin
          if (!m_latched) m_addr = a;
          m_latched = 1'b1;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      total_cnt++; if ({err_latched, err_addr, err_cnt} !== {m_latched, m_addr, 8'(m_cnt)}) $display("FAIL rnd_err_state[%0d]: got %0h/%0h/%0d exp %0h/%0h/%0d", i, err_latched, err_addr, err_cnt, m_latched, m_addr, m_cnt); else pass_cnt++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_gen();
    test_chk();
    test_sticky();
    test_arb();
    test_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
